// File: rtl/run_detector_pkg.sv
// Shared constants for the run-length detector: detection mode encoding and
// the helper that decides whether a sample value is eligible for flagging.
package run_detector_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic mode_selects(input logic [1:0] mode, input logic bit_val);
        case (mode)
            MODE_OFF:  return 1'b0;
            MODE_ZERO: return ~bit_val;
            MODE_ONE:  return bit_val;
            MODE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. When clr and inc are both high the count restarts
// at 1, which lets the run counter begin a fresh run in a single cycle.
module sat_counter #(
    parameter int             W   = 4,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : cnt;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || inc) begin
            cnt <= (inc && (base != MAX)) ? base + 1'b1 : base;
        end
    end

    assign at_max = (cnt == MAX);

endmodule

// File: rtl/run_detector.sv
// Programmable run-length detector: flags samples that complete a run of at
// least run_len_i identical bits and counts each qualifying run once.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int MAX_RUN = 15,
    parameter int CNT_W   = $clog2(MAX_RUN + 1),
    parameter int HIT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             a_i,
    input  logic [CNT_W-1:0] run_len_i,
    input  logic [1:0]       mode_i,
    output logic             flag_o,
    output logic             flag_val_o,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic [HIT_W-1:0] hit_cnt_o,
    output logic             hit_ovf_o
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_RUN);

    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_n;
    logic [HIT_W-1:0] hit_q;
    logic             run_at_max;
    logic             hit_at_max;
    logic             last_q;
    logic             det_q;
    logic             ovf_q;
    logic             accept;
    logic             new_run;
    logic             hit;

    assign accept  = valid_i & ~clr_i;
    assign new_run = (run_q == '0) || (a_i != last_q);

    always_comb begin
        if (new_run) begin
            run_n = CNT_W'(1);
        end else if (run_at_max) begin
            run_n = run_q;
        end else begin
            run_n = run_q + 1'b1;
        end
    end

    assign flag_o     = accept && (run_len_i != '0) && (run_n >= run_len_i)
                        && mode_selects(mode_i, a_i);
    assign flag_val_o = flag_o & a_i;

    // A run already flagged on the previous sample is not counted again.
    assign hit = flag_o & ~(det_q & (a_i == last_q));

    sat_counter #(
        .W   (CNT_W),
        .MAX (RUN_MAX)
    ) u_run_cnt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .inc    (accept),
        .clr    (clr_i | (accept & new_run)),
        .cnt    (run_q),
        .at_max (run_at_max)
    );

    sat_counter #(
        .W   (HIT_W),
        .MAX ({HIT_W{1'b1}})
    ) u_hit_cnt (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .inc    (hit),
        .clr    (clr_i),
        .cnt    (hit_q),
        .at_max (hit_at_max)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
            det_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clr_i) begin
            last_q <= 1'b0;
            det_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (valid_i) begin
            last_q <= a_i;
            det_q  <= flag_o;
            if (hit && hit_at_max) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign run_cnt_o = run_q;
    assign hit_cnt_o = hit_q;
    assign hit_ovf_o = ovf_q;

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a sample-history model.
module tb_run_detector;

    localparam int MAX_RUN = 15;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             clr = 1'b0;
    logic             valid = 1'b0;
    logic             a = 1'b0;
    logic [CNT_W-1:0] run_len = 4'd4;
    logic [1:0]       mode = 2'b11;

    logic             flag8, fval8, ovf8;
    logic [CNT_W-1:0] run8;
    logic [7:0]       hit8;
    logic             flag2, fval2, ovf2;
    logic [CNT_W-1:0] run2;
    logic [1:0]       hit2;

    int n_checks = 0;
    int n_fail   = 0;

    run_detector #(.MAX_RUN(MAX_RUN), .HIT_W(8)) dut8 (
        .clk_i(clk), .rst_n(rst_n), .clr_i(clr), .valid_i(valid), .a_i(a),
        .run_len_i(run_len), .mode_i(mode), .flag_o(flag8), .flag_val_o(fval8),
        .run_cnt_o(run8), .hit_cnt_o(hit8), .hit_ovf_o(ovf8)
    );

    run_detector #(.MAX_RUN(MAX_RUN), .HIT_W(2)) dut2 (
        .clk_i(clk), .rst_n(rst_n), .clr_i(clr), .valid_i(valid), .a_i(a),
        .run_len_i(run_len), .mode_i(mode), .flag_o(flag2), .flag_val_o(fval2),
        .run_cnt_o(run2), .hit_cnt_o(hit2), .hit_ovf_o(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted samples since the last clear/reset, total hits since then,
    // and whether the previous accepted sample was flagged.
    bit hist[$];
    int hits = 0;
    bit prev_flag = 0;

    function automatic int trail_len();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
        end
        return (n > MAX_RUN) ? MAX_RUN : n;
    endfunction

    function automatic int len_with(input bit v);
        int t;
        if (hist.size() == 0 || hist[hist.size()-1] != v) return 1;
        t = trail_len() + 1;
        return (t > MAX_RUN) ? MAX_RUN : t;
    endfunction

    always @(negedge clk) begin
        bit ef;
        bit h;
        if (!rst_n) begin
            hist.delete();
            hits = 0;
            prev_flag = 0;
        end
        chk("run_cnt8", run8, trail_len());
        chk("run_cnt2", run2, trail_len());
        chk("hit_cnt8", hit8, (hits > 255) ? 255 : hits);
        chk("hit_ovf8", ovf8, hits > 255);
        chk("hit_cnt2", hit2, (hits > 3) ? 3 : hits);
        chk("hit_ovf2", ovf2, hits > 3);
        ef = valid && !clr && (run_len != 0) && (len_with(a) >= int'(run_len))
             && mode[a];
        chk("flag8", flag8, ef);
        chk("flag2", flag2, ef);
        chk("flag_val8", fval8, ef & a);
        chk("flag_val2", fval2, ef & a);
        if (rst_n) begin
            if (clr) begin
                hist.delete();
                hits = 0;
                prev_flag = 0;
            end else if (valid) begin
                h = ef && !(prev_flag && hist.size() > 0 && hist[hist.size()-1] == a);
                if (h) hits++;
                prev_flag = ef;
                hist.push_back(a);
                while (hist.size() > MAX_RUN + 1) void'(hist.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic d, output logic f, output logic fv);
        @(posedge clk);
        #1;
        clr = 1'b0;
        valid = v;
        a = d;
        @(negedge clk);
        f = flag8;
        fv = fval8;
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1;
        clr = 1'b1;
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_seq(input int n, input logic [31:0] bits,
                           output logic [31:0] flags, output logic any_fv);
        logic f, fv;
        flags = '0;
        any_fv = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], f, fv);
            flags = {flags[30:0], f};
            any_fv |= fv;
        end
    endtask

    initial begin
        logic [31:0] fl;
        logic        afv, f, fv;
        int          nflags;

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_run", run8, 0);
        chk("reset_hit", hit8, 0);
        chk("reset_ovf", ovf8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zeros run, both modes.
        run_len = 4'd4; mode = 2'b11;
        clr_pulse();
        run_seq(6, 32'b000001, fl, afv);
        chk("t1_flags", fl, 32'b000110);
        chk("t1_flagval", afv, 0);
        step(1'b0, 1'b0, f, fv);
        chk("t1_hit", hit8, 1);
        chk("t1_run", run8, 1);

        // Ones only.
        mode = 2'b10;
        clr_pulse();
        run_seq(12, 32'b111011110000, fl, afv);
        chk("t2_flags", fl, 32'b000000010000);
        step(1'b0, 1'b0, f, fv);
        chk("t2_hit", hit8, 1);

        // Gaps do not break a run.
        mode = 2'b11;
        clr_pulse();
        fl = '0;
        step(1'b1, 1'b1, f, fv); fl = {fl[30:0], f};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), f, fv); fl = {fl[30:0], f};
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, f, fv); fl = {fl[30:0], f};
        end
        chk("t3_flags", fl, 32'b0000001);

        // Saturating run counter.
        run_len = 4'd15;
        clr_pulse();
        run_seq(20, 32'hFFFFF, fl, afv);
        chk("t4_flags", fl, 32'h0003F);
        step(1'b0, 1'b0, f, fv);
        chk("t4_run", run8, 15);
        chk("t4_hit", hit8, 1);

        // Hit counter saturation and overflow on the narrow instance.
        run_len = 4'd1;
        clr_pulse();
        run_seq(4, 32'b0101, fl, afv);
        chk("t5_flags", fl, 32'b1111);
        step(1'b0, 1'b0, f, fv);
        chk("t5_hit2", hit2, 3);
        chk("t5_ovf2", ovf2, 1);
        chk("t5_hit8", hit8, 4);
        step(1'b1, 1'b0, f, fv);
        clr_pulse();
        step(1'b0, 1'b0, f, fv);
        chk("t5_clr_run", run2, 0);
        chk("t5_clr_hit", hit2, 0);
        chk("t5_clr_ovf", ovf2, 0);

        // Reset mid-run, then threshold zero disables detection.
        run_len = 4'd4;
        clr_pulse();
        run_seq(3, 32'b000, fl, afv);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_run", run8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_seq(4, 32'b0000, fl, afv);
        chk("t6_flags", fl, 32'b0001);
        run_len = 4'd0;
        nflags = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), f, fv);
            nflags += int'(f);
        end
        chk("t6_len0", nflags, 0);

        // Randomized traffic.
        mode = 2'b11;
        run_len = 4'd3;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                valid = 1'b0;
                clr = 1'b0;
            end else begin
                rst_n = 1'b1;
                clr = ($urandom_range(0, 49) == 0);
                valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0) a = ~a;
                if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) run_len = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length detector for a serial bit stream. It flags when the current sample completes a run of at least `run_len_i` identical values. The value being detected is selectable: zeros, ones or both. It also keeps a saturating count of detected runs. It is the programmable successor of the fixed 4-zeros/4-ones sequence detector and sits in the same spot, between a synchronised serial input and board-level indicators or counters.

## Interface
- `MAX_RUN`, 15: largest run length tracked; the run counter saturates here. Legal range is 2 or more.
- `CNT_W`, $clog2(MAX_RUN+1): width of the run counter and threshold. Derived; do not override.
- `HIT_W`, 8: width of the detected-run counter.

Ports:
- `clk_i` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr_i` in 1: synchronous clear of all state. It has priority over `valid_i`.
- `valid_i` in 1: `a_i` carries a sample this cycle.
- `a_i` in 1: serial data bit.
- `run_len_i` in CNT_W: detection threshold. Legal values are 1..MAX_RUN; 0 disables detection.
- `mode_i` in 2: 00 off, 01 detect zeros, 10 detect ones, 11 detect both.
- `flag_o` out 1: the current sample completes a qualifying run (Mealy output).
- `flag_val_o` out 1: value of the run being flagged. Equals `a_i` when `flag_o` is high, otherwise 0.
- `run_cnt_o` out CNT_W: length of the current run, registered.
- `hit_cnt_o` out HIT_W: number of detected runs, saturating.
- `hit_ovf_o` out 1: sticky; set when a hit arrives while `hit_cnt_o` is all-ones.

## Operation
Registers:
- `run_q`: run counter.
- `last_q`: last sample value.
- `det_q`: the previous valid sample was flagged.
- `hit_q`: detected-run counter.
- `ovf_q`: overflow flag.

Reset and clear values are 0 for all of them; there is no prior history after reset.

Combinational next-run value:
- `run_n` = 1 if `run_q` == 0 or `a_i` != `last_q`.
- Otherwise `run_n` = min(`run_q`+1, MAX_RUN).

Detection:
- `flag_o` = `valid_i` & ~`clr_i` & (`run_len_i` != 0) & (`run_n` >= `run_len_i`) & `mode_i`[`a_i`].
- The flag stays high on every further sample of the same run, including after the counter saturates. Overlapping detection is intended.

Hit rule:
- `hit` = `flag_o` & ~(`det_q` & (`a_i` == `last_q`)).
- A run is counted exactly once, on its first flagged sample.
- If `run_len_i` drops mid-run, so that an ongoing run becomes qualifying, that run counts once.

Update on `valid_i` & ~`clr_i`:
- `run_q` <= `run_n`, `last_q` <= `a_i`, `det_q` <= `flag_o`.
- On `hit`: if `hit_q` is not all-ones, `hit_q` increments; otherwise `hit_q` holds and `ovf_q` <= 1.

Other cases:
- `valid_i` low: all registers hold and `flag_o` = 0. Gaps in the stream do not break a run.
- `clr_i` high: all registers go to 0 at the next edge and `flag_o` = 0 in the same cycle.
- `mode_i` or `run_len_i` changing mid-run affects only detection. `run_q` always tracks runs of either value regardless of mode.

## Timing
- `flag_o` and `flag_val_o` are combinational from `a_i`, `valid_i`, `mode_i`, `run_len_i` and the registers. Latency is 0 cycles; the flag rises in the cycle the completing bit is presented.
- `run_cnt_o`, `hit_cnt_o` and `hit_ovf_o` are registered. They reflect a sample one cycle after it is accepted.
- Asynchronous reset clears all registers immediately, including mid-run. The run restarts from the first valid sample after reset is released.
- There is no handshake; a sample is consumed every cycle `valid_i` is high.
- `hit_q` saturates; it does not wrap. `ovf_q` clears only on reset or `clr_i`.

## Structure
- Package `run_detector_pkg` holds the `MODE_OFF`/`MODE_ZERO`/`MODE_ONE`/`MODE_BOTH` constants, typed as a 2-bit localparam set.
- Sub-module `sat_counter`, parameter `W`, with inputs `inc`, `clr` and outputs `cnt`, `at_max`. It is instantiated for `run_q` (saturating at MAX_RUN) and for `hit_q` (saturating at all-ones).

## Test plan
- Setup: `run_len_i`=4, mode 11. Input 0,0,0,0,0,1 -> `flag_o` high on the 4th and 5th samples with `flag_val_o`=0; `hit_cnt_o`=1; `run_cnt_o`=1 after the final 1.
- Setup: `run_len_i`=4, mode 10. Input 1,1,1,0,1,1,1,1 followed by 0,0,0,0 -> a single flag, on the 8th sample; zeros are never flagged; `hit_cnt_o`=1.
- Setup: `valid_i` gaps. Input 1,(idle 3 cycles),1,1,1 with `run_len_i`=4 -> flag on the last 1; `flag_o`=0 during the idle cycles.
- Setup: `run_len_i`=MAX_RUN. Drive 20 ones -> `run_cnt_o` stops at 15; flag is high on samples 15..20; `hit_cnt_o`=1.
- Setup: HIT_W=2, `run_len_i`=1, mode 11. Drive 0,1,0,1,0 -> `hit_cnt_o`=3 with `hit_ovf_o`=1 after the 4th sample; `clr_i` pulse -> everything back to 0.
- Setup: `rst_n` asserted after three zeros, then released. Drive 0,0,0,0 -> flag only on the 4th post-reset zero; `run_len_i`=0 -> flag is never asserted.
